motor_cmd_ramp: RTL and testbench

Command-shaping stage directly upstream of the PWM generator: accepts target speed/direction commands over a valid/ready handshake and drives the PWM 4-bit `data_in` with a slew-limited version of the target. Speed steps by one code every STEP_CYCLES clocks. A direction reversal always decelerates to zero, holds zero for DWELL_CYCLES, then flips direction and re-accelerates. It runs in the same divided clock domain as the PWM instance.

---
 rtl/motor_cmd_pkg.sv | 30 +++
 rtl/ramp_timer.sv | 39 +++
 rtl/motor_cmd_ramp.sv | 160 ++++++++++++++++
 tb/tb_motor_cmd_ramp.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/motor_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motor_cmd_pkg
// Description : Shared widths, FSM state encoding and the saturating speed
//               step helper for the motor command ramp stage.
// Revision    : 1.0  initial release
// ============================================================================
package motor_cmd_pkg;

  localparam int CMD_W   = 4;
  localparam int DIR_BIT = 3;
  localparam int SPD_W   = 3;
  localparam logic [SPD_W-1:0] SPD_MAX = 3'd7;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RAMP  = 2'd1,
    DWELL = 2'd2
  } state_e;

  // One code toward goal; pinned at 0 and SPD_MAX so it can never wrap.
  function automatic logic [SPD_W-1:0] step_toward(input logic [SPD_W-1:0] cur,
                                                   input logic [SPD_W-1:0] goal);
    if ((cur < goal) && (cur != SPD_MAX)) return cur + 3'd1;
    if ((cur > goal) && (cur != '0))      return cur - 3'd1;
    return cur;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ramp_timer.sv
`default_nettype none
// ============================================================================
// Module      : ramp_timer
// Description : Loadable down-counter with expiry flag; times both the speed
//               step interval and the zero-speed dwell.
// Ports       : clk, rst        clock / synchronous active-high reset
//               load_i          load load_val_i this edge
//               load_val_i      reload value (interval - 1)
//               expired_o       count is zero
// Revision    : 1.0  initial release
// ============================================================================
module ramp_timer #(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          expired_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  // Counts down freely and parks at zero until reloaded.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/motor_cmd_ramp.sv
`default_nettype none
// ============================================================================
// Module      : motor_cmd_ramp
// Description : Slew-limits target speed/direction commands for the PWM
//               stage. Speed moves one code every STEP_CYCLES clocks; a
//               reversal decelerates to zero, dwells DWELL_CYCLES, flips dir
//               and re-accelerates.
// Ports       : clk, rst        clock / synchronous active-high reset
//               cmd_valid/ready command handshake
//               cmd_data        [3]=dir, [2:0]=speed target
//               data_out        [3]=dir, [2:0]=speed to PWM data_in
//               at_target       HOLD and data_out == target
//               busy            RAMP or DWELL
//               estop           (RAMP_ESTOP_EN only) force speed to zero
// Macro       : RAMP_ESTOP_EN adds the estop input.
// Revision    : 1.0  initial release
// ============================================================================
module motor_cmd_ramp
  import motor_cmd_pkg::*;
#(
  parameter int STEP_CYCLES  = 1000,
  parameter int DWELL_CYCLES = 500
) (
  input  logic             clk,
  input  logic             rst,
`ifdef RAMP_ESTOP_EN
  input  logic             estop,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CMD_W-1:0] cmd_data,
  output logic [CMD_W-1:0] data_out,
  output logic             at_target,
  output logic             busy
);

  localparam int MAX_CYC = (STEP_CYCLES > DWELL_CYCLES) ? STEP_CYCLES : DWELL_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] STEP_LOAD  = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [CMD_W-1:0]       target_q, target_d;
  logic [CMD_W-1:0]       dout_q, dout_d;
  logic                   tmr_load;
  logic [TW-1:0]          tmr_val;
  logic                   tmr_exp;

  logic                   cur_dir, tgt_dir, accept;
  logic [SPD_W-1:0]       cur_spd, tgt_spd, goal_spd, nxt_spd;

  assign cur_dir  = dout_q[DIR_BIT];
  assign cur_spd  = dout_q[SPD_W-1:0];
  assign tgt_dir  = target_q[DIR_BIT];
  assign tgt_spd  = target_q[SPD_W-1:0];
  // Opposite direction requested: head for zero first.
  assign goal_spd = (tgt_dir == cur_dir) ? tgt_spd : '0;
  assign nxt_spd  = step_toward(cur_spd, goal_spd);
  assign accept   = cmd_valid & cmd_ready;

  ramp_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_exp)
  );

`ifdef RAMP_ESTOP_EN
  logic estop_q;
  always_ff @(posedge clk) begin
    if (rst) estop_q <= 1'b0;
    else     estop_q <= estop;
  end
  assign cmd_ready = (state_q != DWELL) && !estop_q;
`else
  assign cmd_ready = (state_q != DWELL);
`endif

  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    target_d = accept ? cmd_data : target_q;
    tmr_load = 1'b0;
    tmr_val  = STEP_LOAD;

    case (state_q)
      HOLD: begin
        if (dout_q == target_q) begin
          state_d = HOLD;
        end else if ((cur_spd == '0) && (cur_dir != tgt_dir)) begin
          // Already stopped: flip direction immediately, no dwell.
          dout_d = {tgt_dir, cur_spd};
        end else begin
          state_d  = RAMP;
          tmr_load = 1'b1;
          tmr_val  = STEP_LOAD;
        end
      end
      RAMP: begin
        // Step timer is never restarted by new commands; goal is
        // re-evaluated only at each step.
        if (tmr_exp) begin
          dout_d   = {cur_dir, nxt_spd};
          tmr_load = 1'b1;
          tmr_val  = STEP_LOAD;
          if (nxt_spd == goal_spd) begin
            if (cur_dir != tgt_dir) begin
              state_d = DWELL;
              tmr_val = DWELL_LOAD;
            end else if (nxt_spd == tgt_spd) begin
              state_d = HOLD;
            end
          end
        end
      end
      DWELL: begin
        if (tmr_exp) begin
          dout_d = {tgt_dir, cur_spd};
          if (tgt_spd != '0) begin
            state_d  = RAMP;
            tmr_load = 1'b1;
            tmr_val  = STEP_LOAD;
          end else begin
            state_d = HOLD;
          end
        end
      end
      default: state_d = HOLD;
    endcase

`ifdef RAMP_ESTOP_EN
    if (estop) begin
      state_d  = HOLD;
      dout_d   = {cur_dir, {SPD_W{1'b0}}};
      target_d = {cur_dir, {SPD_W{1'b0}}};
      tmr_load = 1'b1;
      tmr_val  = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HOLD;
      target_q <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      dout_q   <= dout_d;
    end
  end

  assign data_out  = dout_q;
  assign at_target = (state_q == HOLD) && (dout_q == target_q);
  assign busy      = (state_q != HOLD);

endmodule
`default_nettype wire

// File: tb/tb_motor_cmd_ramp.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_cmd_ramp
// Description : Directed scoreboard bench for motor_cmd_ramp with
//               STEP_CYCLES=4, DWELL_CYCLES=3. Every data_out change is
//               matched against an expected (value, edge index) entry.
// Revision    : 1.0  initial release
// ============================================================================
module tb_motor_cmd_ramp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_data = 4'b0000;
  logic [3:0] data_out;
  logic       at_target;
  logic       busy;
`ifdef RAMP_ESTOP_EN
  logic       estop = 1'b0;
`endif

  motor_cmd_ramp #(.STEP_CYCLES(4), .DWELL_CYCLES(3)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef RAMP_ESTOP_EN
    .estop     (estop),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .data_out  (data_out),
    .at_target (at_target),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Edge index: after posedge k, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [3:0] data; int at; } exp_t;
  exp_t exp_q[$];

  int  vecs = 0;
  int  errs = 0;
  bit  mon_en = 1'b0;
  bit  done = 1'b0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %b expected %b (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [3:0] d, input int at);
    exp_t e;
    e.data = d;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; command accepted on the following posedge, n = that edge.
  task automatic send(input logic [3:0] c, output int n);
    chk("cmd_ready_before_send", {3'b000, cmd_ready}, 4'b0001);
    cmd_data  = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every change of data_out must match the next expected entry.
  initial begin
    logic [3:0] last;
    exp_t e;
    wait (mon_en);
    last = data_out;
    forever begin
      @(negedge clk);
      if (done) break;
      if (data_out !== last) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL data_out_unexpected: got %b at edge %0d, nothing expected", data_out, cyc);
        end else begin
          e = exp_q.pop_front();
          if (data_out !== e.data || cyc != e.at) begin
            errs++;
            $display("FAIL data_out_step: got %b at edge %0d expected %b at edge %0d",
                     data_out, cyc, e.data, e.at);
          end
        end
        last = data_out;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d expectations pending", exp_q.size());
    errs++;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    int n, m;

    // Reset for two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_data_out",  data_out, 4'b0000);
    chk("reset_at_target", {3'b000, at_target}, 4'b0001);
    chk("reset_busy",      {3'b000, busy},      4'b0000);
    chk("reset_cmd_ready", {3'b000, cmd_ready}, 4'b0001);
    mon_en = 1'b1;

    // From rest to 0101: first step 4 clocks after RAMP entry
    send(4'b0101, n);
    for (int i = 1; i <= 5; i++) push(4'(i), n + 1 + 4 * i);
    wait_until(n + 1);
    chk("ramp_busy", {3'b000, busy}, 4'b0001);
    wait_until(n + 20);
    chk("at_target_before_final", {3'b000, at_target}, 4'b0000);
    wait_until(n + 21);
    chk("at_target_after_final", {3'b000, at_target}, 4'b0001);

    // Down to 0011 steady
    @(negedge clk);
    send(4'b0011, n);
    push(4'b0100, n + 5);
    push(4'b0011, n + 9);
    wait_until(n + 10);
    chk("hold_0011_at_target", {3'b000, at_target}, 4'b0001);

    // Reversal 0011 -> 1010 with dwell
    send(4'b1010, n);
    push(4'b0010, n + 5);
    push(4'b0001, n + 9);
    push(4'b0000, n + 13);
    push(4'b1000, n + 16);
    push(4'b1001, n + 20);
    push(4'b1010, n + 24);
    for (int i = 12; i <= 16; i++) begin
      wait_until(n + i);
      chk($sformatf("dwell_cmd_ready_%0d", i), {3'b000, cmd_ready},
          {3'b000, (i >= 13 && i <= 15) ? 1'b0 : 1'b1});
    end
    wait_until(n + 24);
    chk("reversal_at_target", {3'b000, at_target}, 4'b0001);

    // Reverse to zero: dwell then HOLD at 0000
    @(negedge clk);
    send(4'b0000, n);
    push(4'b1001, n + 5);
    push(4'b1000, n + 9);
    push(4'b0000, n + 12);
    wait_until(n + 11);
    chk("dwell_busy", {3'b000, busy}, 4'b0001);
    wait_until(n + 12);
    chk("dwell_to_hold_at_target", {3'b000, at_target}, 4'b0001);

    // Ramp toward 0111, retarget to 0001 at speed 3 without timer restart
    @(negedge clk);
    send(4'b0111, n);
    push(4'b0001, n + 5);
    push(4'b0010, n + 9);
    push(4'b0011, n + 13);
    wait_until(n + 14);
    send(4'b0001, m);
    push(4'b0010, n + 17);
    push(4'b0001, n + 21);
    wait_until(n + 20);
    chk("retarget_busy", {3'b000, busy}, 4'b0001);
    wait_until(n + 21);
    chk("retarget_at_target", {3'b000, at_target}, 4'b0001);

    // To 0000, then 1000: immediate dir flip without dwell
    @(negedge clk);
    send(4'b0000, n);
    push(4'b0000, n + 5);
    wait_until(n + 5);
    @(negedge clk);
    send(4'b1000, n);
    push(4'b1000, n + 1);
    wait_until(n + 1);
    chk("flip_at_target", {3'b000, at_target}, 4'b0001);
    chk("flip_cmd_ready", {3'b000, cmd_ready}, 4'b0001);
    chk("flip_busy",      {3'b000, busy},      4'b0000);

    // Ramp 0111 from 1000, reset at speed 4
    @(negedge clk);
    send(4'b0111, n);
    push(4'b0000, n + 1);
    for (int i = 1; i <= 4; i++) push(4'(i), n + 2 + 4 * i);
    wait_until(n + 19);
    push(4'b0000, n + 20);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midramp_rst_data_out",  data_out, 4'b0000);
    chk("midramp_rst_at_target", {3'b000, at_target}, 4'b0001);
    chk("midramp_rst_busy",      {3'b000, busy},      4'b0000);
    chk("midramp_rst_cmd_ready", {3'b000, cmd_ready}, 4'b0001);

    // Fresh ramp from 0 after reset
    send(4'b0010, n);
    push(4'b0001, n + 5);
    push(4'b0010, n + 9);
    wait_until(n + 9);
    chk("post_rst_at_target", {3'b000, at_target}, 4'b0001);

    repeat (6) @(negedge clk);
    done = 1'b1;
    chk("scoreboard_drained", 4'(exp_q.size()), 4'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
